dmem_arbiter: RTL and testbench

Data-memory access controller between the MIPS core's load/store port, a second requester (program loader / debug port) and the single-port word-addressed data RAM. It arbitrates round-robin between the two requesters and sequences each access with a request/grant/response handshake. It owns the RAM strobes, so the RAM sees at most one access per cycle. It also provides a hardware clear sequencer that zero-fills the whole RAM on command.

---
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory access controller: round-robin arbitration of two requesters onto a
// single-port word RAM, with a hardware zero-fill sequencer.
module dmem_arbiter #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, CLEAR} state_t;

  state_t             state;
  logic               rr_ptr;
  logic               clear_pend;
  logic               cur_id;
  logic               cur_we;
  logic               cur_ok;
  logic [CNT_W-1:0]   clr_cnt;

  logic               pick;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [ADDR_W-1:0]  sel_idx;
  logic               sel_ok;

  // pick = 1 selects requester 1; a lone requester wins regardless of rr_ptr
  always_comb begin
    pick = 1'b0;
    if (r0_req && r1_req) pick = rr_ptr;
    else                  pick = r1_req;
    sel_we    = pick ? r1_we    : r0_we;
    sel_addr  = pick ? r1_addr  : r0_addr;
    sel_wdata = pick ? r1_wdata : r0_wdata;
    sel_idx   = sel_addr >> 2;
    sel_ok    = sel_idx < ADDR_W'(DEPTH);
  end

  // Strobes and grants are registered on leaving IDLE so they appear in the ACCESS
  // cycle; read data is passed straight through during RESP since the RAM returns it then.
  assign r0_rdata = (r0_rvalid && cur_ok) ? mem_rdata : '0;
  assign r1_rdata = (r1_rvalid && cur_ok) ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      clear_pend <= 1'b0;
      cur_id     <= 1'b0;
      cur_we     <= 1'b0;
      cur_ok     <= 1'b0;
      clr_cnt    <= '0;
      r0_gnt     <= 1'b0;
      r1_gnt     <= 1'b0;
      r0_err     <= 1'b0;
      r1_err     <= 1'b0;
      r0_rvalid  <= 1'b0;
      r1_rvalid  <= 1'b0;
      clear_busy <= 1'b0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_err    <= 1'b0;
      r1_err    <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      case (state)
        IDLE: begin
          if (clear_start || clear_pend) begin
            state      <= CLEAR;
            clear_pend <= 1'b0;
            clr_cnt    <= '0;
            clear_busy <= 1'b1;
            mem_we     <= 1'b1;
          end else if (r0_req || r1_req) begin
            state  <= ACCESS;
            cur_id <= pick;
            cur_we <= sel_we;
            cur_ok <= sel_ok;
            rr_ptr <= ~pick;
            r0_gnt <= ~pick;
            r1_gnt <= pick;
            r0_err <= ~pick & ~sel_ok;
            r1_err <= pick & ~sel_ok;
            if (sel_ok) begin
              mem_we    <= sel_we;
              mem_re    <= ~sel_we;
              mem_addr  <= {sel_addr[ADDR_W-1:2], 2'b00};
              mem_wdata <= sel_we ? sel_wdata : '0;
            end
          end
        end
        ACCESS: begin
          if (clear_start) clear_pend <= 1'b1;
          if (cur_we) begin
            state <= IDLE;
          end else begin
            state     <= RESP;
            r0_rvalid <= ~cur_id;
            r1_rvalid <= cur_id;
          end
        end
        RESP: begin
          if (clear_start) clear_pend <= 1'b1;
          state <= IDLE;
        end
        CLEAR: begin
          if (clr_cnt == CNT_W'(DEPTH - 1)) begin
            state      <= IDLE;
            clear_busy <= 1'b0;
          end else begin
            clr_cnt  <= clr_cnt + CNT_W'(1);
            mem_we   <= 1'b1;
            mem_addr <= ADDR_W'(clr_cnt + CNT_W'(1)) << 2;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural RAM, reference memory model and
// a response scoreboard popped whenever an rvalid pulse appears.
module tb_dmem_arbiter;

  localparam int unsigned DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic        clear_start, clear_busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  dmem_arbiter #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural single-port RAM with one cycle read latency
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_we && mem_addr[31:2] < DEPTH) ram[mem_addr[6:2]] <= mem_wdata;
    if (mem_re && mem_addr[31:2] < DEPTH) mem_rdata <= ram[mem_addr[6:2]];
  end

  typedef struct { bit id; logic [31:0] data; } rsp_t;
  rsp_t        exp_q[$];
  logic [31:0] model [DEPTH];
  int          total = 0;
  int          bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("strobe_excl", {31'd0, mem_we & mem_re}, 32'd0);
    if (!r0_rvalid) check("r0_rdata_idle", r0_rdata, 32'd0);
    if (!r1_rvalid) check("r1_rdata_idle", r1_rdata, 32'd0);
    if (r0_rvalid || r1_rvalid) begin
      if (exp_q.size() == 0) begin
        check("rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rvalid_id", {31'd0, r1_rvalid}, {31'd0, e.id});
        check("rdata", r1_rvalid ? r1_rdata : r0_rdata, e.data);
      end
    end
  end

  task automatic check_quiet(input string tag);
    check({tag, "_flags"}, {23'd0, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_err, r1_err,
                            clear_busy, mem_we, mem_re}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_rdata"}, r0_rdata | r1_rdata, 32'd0);
  endtask

  task automatic drive(input bit id, input bit req, input bit we, input logic [31:0] a,
                       input logic [31:0] d);
    if (id) begin r1_req = req; r1_we = we; r1_addr = a; r1_wdata = d; end
    else    begin r0_req = req; r0_we = we; r0_addr = a; r0_wdata = d; end
  endtask

  // one access from an idle DUT; called on a negedge, returns on a negedge with DUT idle
  task automatic access(input bit id, input bit we, input logic [31:0] a,
                        input logic [31:0] d, input bit exp_err);
    int unsigned start;
    bit got;
    rsp_t e;
    drive(id, 1'b1, we, a, d);
    start = cyc;
    if (!we) begin
      e.id = id;
      e.data = exp_err ? 32'd0 : model[a[6:2]];
      exp_q.push_back(e);
    end else if (!exp_err) begin
      model[a[6:2]] = d;
    end
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (id ? r1_gnt : r0_gnt) got = 1'b1;
    end
    drive(id, 1'b0, 1'b0, 32'd0, 32'd0);
    check("gnt_seen", {31'd0, got}, 32'd1);
    if (got) begin
      check("gnt_latency", cyc - start, 32'd1);
      check("other_gnt", {31'd0, id ? r0_gnt : r1_gnt}, 32'd0);
      check("err", {31'd0, id ? r1_err : r0_err}, {31'd0, exp_err});
      check("other_err", {31'd0, id ? r0_err : r1_err}, 32'd0);
      check("mem_we", {31'd0, mem_we}, {31'd0, we & ~exp_err});
      check("mem_re", {31'd0, mem_re}, {31'd0, ~we & ~exp_err});
      check("mem_addr", mem_addr, exp_err ? 32'd0 : {a[31:2], 2'b00});
      if (we && !exp_err) check("mem_wdata", mem_wdata, d);
    end
    if (!we) begin
      @(negedge clk);
      check("rvalid_latency", {31'd0, id ? r1_rvalid : r0_rvalid}, 32'd1);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned start, g, last, busy_n;
    int k;
    bit got;
    logic [31:0] d0, d1;

    reset = 1'b1; clear_start = 1'b0;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;

    // contention: both write continuously, grants alternate r0 first, every 2 cycles
    d0 = 32'hA000_0000; d1 = 32'hB000_0000;
    drive(0, 1, 1, 32'h10, d0);
    drive(1, 1, 1, 32'h14, d1);
    start = cyc; last = 0; k = 0;
    for (int n = 0; n < 40 && k < 8; n++) begin
      @(negedge clk);
      check("gnt_onehot", {31'd0, r0_gnt & r1_gnt}, 32'd0);
      if (r0_gnt || r1_gnt) begin
        check("rr_order", {31'd0, r1_gnt}, k % 2);
        check("rr_spacing", cyc - (k == 0 ? start : last), k == 0 ? 32'd1 : 32'd2);
        check("rr_mem_wdata", mem_wdata, r1_gnt ? d1 : d0);
        if (r1_gnt) begin model[5] = d1; d1++; r1_wdata = d1; end
        else        begin model[4] = d0; d0++; r0_wdata = d0; end
        last = cyc; k++;
      end
    end
    check("rr_grants", k, 32'd8);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    access(1, 0, 32'h10, 0, 0);
    access(0, 0, 32'h14, 0, 0);

    // basic write/read, ignored low address bits, last word, out of range
    access(0, 1, 32'h08, 32'hDEADBEEF, 0);
    access(0, 0, 32'h08, 0, 0);
    access(1, 0, 32'h0B, 0, 0);
    access(1, 1, 32'h7C, 32'h1357_9BDF, 0);
    access(0, 0, 32'h7C, 0, 0);
    access(1, 0, 32'h80, 0, 1);
    access(0, 1, 32'h84, 32'hFFFF_FFFF, 1);
    access(0, 0, 32'h7C, 0, 0);

    // clear sweep
    clear_start = 1'b1;
    start = cyc;
    @(negedge clk);
    clear_start = 1'b0;
    check("clr_latency", cyc - start, 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) @(negedge clk);
      check("clr_busy", {31'd0, clear_busy}, 32'd1);
      check("clr_we", {30'd0, mem_we, mem_re}, 32'd2);
      check("clr_addr", mem_addr, i * 4);
      check("clr_wdata", mem_wdata, 32'd0);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
    @(negedge clk);
    check("clr_done", {30'd0, clear_busy, mem_we}, 32'd0);
    access(0, 0, 32'h08, 0, 0);
    access(1, 0, 32'h7C, 0, 0);
    access(0, 0, 32'h10, 0, 0);

    // clear_start during a read's ACCESS, with a new r0 write held across the sweep
    access(1, 1, 32'h08, 32'h1234_5678, 0);
    begin
      rsp_t e;
      e.id = 1'b0; e.data = 32'h1234_5678;
      exp_q.push_back(e);
    end
    drive(0, 1, 0, 32'h08, 0);
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      got = r0_gnt;
    end
    check("cb_read_gnt", {31'd0, got}, 32'd1);
    g = cyc;
    clear_start = 1'b1;
    drive(0, 1, 1, 32'h0C, 32'hA5A5_5A5A);
    @(negedge clk);
    clear_start = 1'b0;
    check("cb_rvalid", {31'd0, r0_rvalid}, 32'd1);
    @(negedge clk);
    check("cb_idle_gap", {30'd0, clear_busy, r0_gnt}, 32'd0);
    busy_n = 0; got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (clear_busy) begin
        if (busy_n == 0) check("cb_sweep_start", cyc - g, 32'd3);
        busy_n++;
      end
      if (r0_gnt || r1_gnt) begin
        got = 1'b1;
        check("cb_gnt_busy", {31'd0, clear_busy}, 32'd0);
      end
    end
    drive(0, 0, 0, 0, 0);
    check("cb_busy_cycles", busy_n, DEPTH);
    check("cb_late_gnt", {31'd0, got & r0_gnt}, 32'd1);
    check("cb_late_gnt_cyc", cyc - g, DEPTH + 4);
    check("cb_late_we", {31'd0, mem_we}, 32'd1);
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
    model[3] = 32'hA5A5_5A5A;
    @(negedge clk);
    access(1, 0, 32'h0C, 0, 0);
    access(1, 0, 32'h08, 0, 0);

    // reset while a read is in flight; rr_ptr last pointed at r1
    access(1, 1, 32'h18, 32'h0BAD_F00D, 0);
    drive(0, 1, 0, 32'h18, 0);
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      got = r0_gnt;
    end
    check("rst_read_gnt", {31'd0, got}, 32'd1);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check_quiet("rst_mid");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_no_rvalid", exp_q.size(), 32'd0);
    drive(0, 1, 1, 32'h1C, 32'h0000_00A0);
    drive(1, 1, 1, 32'h20, 32'h0000_00B0);
    k = 0;
    for (int n = 0; n < 20 && k < 2; n++) begin
      @(negedge clk);
      if (r0_gnt || r1_gnt) begin
        check("rst_rr_order", {31'd0, r1_gnt}, k);
        if (r0_gnt) r0_req = 1'b0;
        if (r1_gnt) r1_req = 1'b0;
        k++;
      end
    end
    check("rst_grants", k, 32'd2);
    model[7] = 32'h0000_00A0;
    model[8] = 32'h0000_00B0;
    @(negedge clk);
    access(0, 0, 32'h1C, 0, 0);
    access(1, 0, 32'h20, 0, 0);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
